// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receive endpoint.
// MSB-first deserialiser with valid/ready output.
module spi_slave_rx #(
  parameter int DATA_W         = 16,
  parameter int SYNC_STAGES    = 2,
  parameter bit SAMPLE_POSEDGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sclk,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overrun,
  input  logic              i_clr_err,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1) + 1;

  localparam logic [CNT_W-1:0] CNT_FULL =
    CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    FULL
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  logic sclk_d;
  logic cs_d;
  logic mosi_d;

  logic samp;
  logic cs_fall;
  logic cs_rise;

  logic [SYNC_STAGES:0] flush;
  logic                 armed;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              can_pub;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign can_pub = ~o_valid | i_ready;

  // input synchronisers, reset to bus-idle levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0],
                    i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],
                    i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0],
                    i_mosi};
    end
  end

  // registered edge pulses; mosi_d stays aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
      mosi_d  <= 1'b0;
      samp    <= 1'b0;
      cs_fall <= 1'b0;
      cs_rise <= 1'b0;
    end else begin
      sclk_d  <= sclk_s;
      cs_d    <= cs_s;
      mosi_d  <= mosi_s;
      samp    <= ~cs_s &
                 (SAMPLE_POSEDGE ?
                  (sclk_s & ~sclk_d) :
                  (~sclk_s & sclk_d));
      cs_fall <= armed & cs_d & ~cs_s;
      cs_rise <= ~cs_d & cs_s;
    end
  end

  // arm only after cs_n is seen truly high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush <= '0;
      armed <= 1'b0;
    end else begin
      flush <= {flush[SYNC_STAGES-1:0], 1'b1};
      if (flush[SYNC_STAGES] && cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  // receive FSM, handshake and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
      if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= RECV;
            bit_cnt <= '0;
            shift   <= '0;
            o_busy  <= 1'b1;
          end
        end
        RECV: begin
          if (cs_rise) begin
            state       <= IDLE;
            o_busy      <= 1'b0;
            o_frame_err <= 1'b1;
          end else if (samp) begin
            shift   <= {shift[DATA_W-2:0],
                        mosi_d};
            bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt == CNT_LAST) begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (cs_rise) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            if (bit_cnt != CNT_FULL) begin
              o_frame_err <= 1'b1;
            end else if (can_pub) begin
              o_data  <= shift;
              o_valid <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
          end else if (samp &&
                       bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed frames against a
// transaction-level model of the receiver outputs.
module tb_spi_slave_rx;

  localparam int DW = 16;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sclk  = 1'b0;
  logic cs_n  = 1'b1;
  logic mosi  = 1'b0;
  logic ready = 1'b0;
  logic clr   = 1'b0;

  logic [DW-1:0] data;
  logic          valid;
  logic          ferr;
  logic          ovr;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  logic          ev  = 1'b0;
  logic          efe = 1'b0;
  logic          eo  = 1'b0;
  logic [DW-1:0] ed  = '0;

  logic          m_v;
  logic          m_fe;
  logic          m_o;
  logic [DW-1:0] m_d;

  bit            pend = 1'b0;
  int            pcnt = 0;
  int            pn   = 0;
  logic [DW-1:0] pv   = '0;

  bit            in_frame = 1'b0;
  int            nbits    = 0;
  logic [DW-1:0] shv      = '0;

  int cnt;

  spi_slave_rx #(
    .DATA_W        (DW),
    .SYNC_STAGES   (SS),
    .SAMPLE_POSEDGE(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(ferr),
    .o_overrun  (ovr),
    .i_clr_err  (clr),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic cs_low();
    tick(1);
    cs_n     = 1'b0;
    in_frame = 1'b1;
    nbits    = 0;
    shv      = '0;
    tick(5);
  endtask

  task automatic send_bits(input logic [31:0] v,
                           input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      tick(5);
      sclk = 1'b1;
      if (in_frame) begin
        shv = {shv[DW-2:0], v[i]};
        nbits++;
      end
      tick(5);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_high();
    tick(5);
    cs_n = 1'b1;
    if (in_frame) begin
      pend = 1'b1;
      pcnt = SS + 1;
      pn   = nbits;
      pv   = shv;
    end
    in_frame = 1'b0;
  endtask

  task automatic frame(input logic [31:0] v,
                       input int n);
    cs_low();
    send_bits(v, n);
    cs_high();
  endtask

  task automatic count_ferr(input int n);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (ferr) cnt++;
    end
  endtask

  // reference model: frame end seen by first
  // sampling edge, outputs updated SS+1 later
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      ev   = 1'b0;
      efe  = 1'b0;
      eo   = 1'b0;
      ed   = '0;
      pend = 1'b0;
    end else begin
      m_v  = ev;
      m_d  = ed;
      m_o  = eo;
      m_fe = 1'b0;
      if (ev && ready) m_v = 1'b0;
      if (clr) m_o = 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          pend = 1'b0;
          if (pn != DW) m_fe = 1'b1;
          else if (!ev || ready) begin
            m_d = pv;
            m_v = 1'b1;
          end else m_o = 1'b1;
        end else pcnt--;
      end
      ev  = m_v;
      ed  = m_d;
      eo  = m_o;
      efe = m_fe;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_valid", 32'(valid), 32'(0));
      check("rst_data", 32'(data), 32'(0));
      check("rst_ferr", 32'(ferr), 32'(0));
      check("rst_ovr", 32'(ovr), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
    end else begin
      check("valid", 32'(valid), 32'(ev));
      check("data", 32'(data), 32'(ed));
      check("frame_err", 32'(ferr), 32'(efe));
      check("overrun", 32'(ovr), 32'(eo));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    tick(4);
    check("t0_busy", 32'(busy), 32'(0));
    check("t0_valid", 32'(valid), 32'(0));
    rst_n = 1'b1;
    tick(10);

    ready = 1'b1;
    cs_low();
    send_bits(32'hF2, 8);
    check("t1_busy_mid", 32'(busy), 32'(1));
    send_bits(32'hCF, 8);
    cs_high();
    tick(3);
    check("t1_lat_early", 32'(valid), 32'(0));
    tick(1);
    check("t1_valid", 32'(valid), 32'(1));
    check("t1_data", 32'(data), 32'h0000F2CF);
    tick(1);
    check("t1_pulse_end", 32'(valid), 32'(0));
    tick(10);
    check("t1_busy_end", 32'(busy), 32'(0));

    ready = 1'b0;
    frame(32'hA5A5, 16);
    tick(24);
    check("t2_hold_valid", 32'(valid), 32'(1));
    check("t2_hold_data", 32'(data), 32'h0000A5A5);
    ready = 1'b1;
    tick(1);
    check("t2_accept", 32'(valid), 32'(0));
    ready = 1'b0;
    tick(10);

    frame(32'h155, 9);
    count_ferr(15);
    check("t3_ferr_pulses", 32'(cnt), 32'(1));
    check("t3_valid", 32'(valid), 32'(0));
    check("t3_data", 32'(data), 32'h0000A5A5);
    tick(5);

    frame(32'h1ABCD, 17);
    count_ferr(15);
    check("t4_ferr_pulses", 32'(cnt), 32'(1));
    check("t4_valid", 32'(valid), 32'(0));
    tick(5);
    frame(32'h1234, 16);
    tick(6);
    check("t4_valid_good", 32'(valid), 32'(1));
    check("t4_data_good", 32'(data), 32'h00001234);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(5);

    frame(32'h0001, 16);
    tick(6);
    check("t5_w0_data", 32'(data), 32'h00000001);
    frame(32'h0002, 16);
    tick(6);
    check("t5_ovr", 32'(ovr), 32'(1));
    check("t5_keep_data", 32'(data), 32'h00000001);
    check("t5_keep_valid", 32'(valid), 32'(1));
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("t5_clr", 32'(ovr), 32'(0));
    frame(32'h0002, 16);
    tick(3);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t5_swap_data", 32'(data), 32'h00000002);
    check("t5_swap_valid", 32'(valid), 32'(1));
    check("t5_swap_ovr", 32'(ovr), 32'(0));
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t5_drain", 32'(valid), 32'(0));
    tick(10);

    cs_low();
    send_bits(32'hAB, 8);
    rst_n    = 1'b0;
    in_frame = 1'b0;
    tick(2);
    check("t6_rst_data", 32'(data), 32'(0));
    check("t6_rst_busy", 32'(busy), 32'(0));
    tick(2);
    rst_n = 1'b1;
    send_bits(32'hCD, 8);
    check("t6_busy_after", 32'(busy), 32'(0));
    cs_high();
    count_ferr(15);
    check("t6_silent", 32'(cnt), 32'(0));
    check("t6_no_valid", 32'(valid), 32'(0));
    tick(10);
    frame(32'h00FF, 16);
    tick(6);
    check("t6_valid", 32'(valid), 32'(1));
    check("t6_data", 32'(data), 32'h000000FF);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
